// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start qualification, centre sampling,
// and a valid/ack holding register with frame-error and overrun reporting.
//
// state     | meaning
// S_IDLE    | line idle, waiting for rxS low
// S_START   | counting to mid start bit to reject glitches
// S_DATA    | sampling 8 data bits LSB first at bit centres
// S_STOP    | sampling the stop bit at its centre
// S_WAIT_HIGH | stop bit was low; hold off until the line returns high

module uart_receiver #(
    parameter int CLOCK_SPEED = 27000000,
    parameter int BAUD_RATE   = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] dataOut,
    output logic       dataValid,
    input  logic       dataAck,
    output logic       frameError,
    output logic       overrun,
    output logic       rxBusy
);

    localparam int          CLOCK_DELAY   = CLOCK_SPEED / BAUD_RATE;
    localparam int          HALF_DELAY    = CLOCK_DELAY / 2;
    localparam logic [31:0] LAST_BIT_CNT  = 32'(CLOCK_DELAY - 1);
    localparam logic [31:0] LAST_HALF_CNT = 32'(HALF_DELAY - 1);

    generate
        if (CLOCK_DELAY < 4) begin : g_bad_rate
            $error("uart_receiver: CLOCK_SPEED / BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic [31:0] r_clk_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_deliver;
    logic [7:0]  r_data_out;
    logic        r_data_valid;
    logic        r_frame_error;
    logic        r_overrun;
    logic        r_busy;

    assign dataOut    = r_data_out;
    assign dataValid  = r_data_valid;
    assign frameError = r_frame_error;
    assign overrun    = r_overrun;
    assign rxBusy     = r_busy;

    // Synchroniser flops reset to the idle (high) line level so no false start follows reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= uart_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_clk_cnt     <= 32'd0;
            r_bit_idx     <= 3'd0;
            r_shift       <= 8'd0;
            r_deliver     <= 1'b0;
            r_data_out    <= 8'd0;
            r_data_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_error <= 1'b0;
            r_deliver     <= 1'b0;

            // A same-cycle ack frees the holding register, so the new byte is taken cleanly.
            if (r_deliver) begin
                if (!r_data_valid || dataAck) begin
                    r_data_out   <= r_shift;
                    r_data_valid <= 1'b1;
                    r_overrun    <= 1'b0;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (dataAck && r_data_valid) begin
                r_data_valid <= 1'b0;
                r_overrun    <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_sync) begin
                        r_state   <= S_START;
                        r_clk_cnt <= 32'd0;
                        r_busy    <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_clk_cnt == LAST_HALF_CNT) begin
                        r_clk_cnt <= 32'd0;
                        if (!r_rx_sync) begin
                            r_state   <= S_DATA;
                            r_bit_idx <= 3'd0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 32'd1;
                    end
                end

                S_DATA: begin
                    if (r_clk_cnt == LAST_BIT_CNT) begin
                        r_clk_cnt          <= 32'd0;
                        r_shift[r_bit_idx] <= r_rx_sync;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 32'd1;
                    end
                end

                S_STOP: begin
                    if (r_clk_cnt == LAST_BIT_CNT) begin
                        r_clk_cnt <= 32'd0;
                        if (r_rx_sync) begin
                            r_deliver <= 1'b1;
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_state       <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 32'd1;
                    end
                end

                S_WAIT_HIGH: begin
                    if (r_rx_sync) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cnt <= 32'd0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 16 clocks per bit (CLOCK_SPEED=1600, BAUD_RATE=100).
module tb_uart_receiver;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rx = 1'b1;
    logic       dataAck = 1'b0;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       frameError;
    logic       overrun;
    logic       rxBusy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_rises = 0;
    int rise_cyc    = 0;
    int fe_pulses   = 0;
    int fe_hi       = 0;
    logic prev_valid = 1'b0;
    logic prev_fe    = 1'b0;

    uart_receiver #(.CLOCK_SPEED(1600), .BAUD_RATE(100)) dut (
        .clock      (clock),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .dataOut    (dataOut),
        .dataValid  (dataValid),
        .dataAck    (dataAck),
        .frameError (frameError),
        .overrun    (overrun),
        .rxBusy     (rxBusy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (dataValid === 1'b1 && prev_valid !== 1'b1) begin
            valid_rises = valid_rises + 1;
            rise_cyc    = cyc;
        end
        prev_valid = dataValid;
        if (frameError === 1'b1) fe_hi = fe_hi + 1;
        if (frameError === 1'b1 && prev_fe !== 1'b1) fe_pulses = fe_pulses + 1;
        prev_fe = frameError;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Leaves the line at the stop level; callers raise it when needed.
    task automatic send_frame(input logic [7:0] d, input logic stop_val, input int stop_bits);
        uart_rx = 1'b0;
        wait_cycles(16);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            wait_cycles(16);
        end
        uart_rx = stop_val;
        wait_cycles(16 * stop_bits);
    endtask

    task automatic pulse_ack();
        dataAck = 1'b1;
        @(posedge clock);
        #1;
        dataAck = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cycles(3);
        n_checks++; if (dataOut !== 8'h00) begin n_fail++; $display("FAIL reset_dataOut: got %h expected 00", dataOut); end
        n_checks++; if ({dataValid, frameError, overrun, rxBusy} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {dataValid, frameError, overrun, rxBusy}); end
        reset = 1'b0;
        wait_cycles(4);
    endtask

    task automatic test_basic();
        int r0, f0, start, lat;
        r0 = valid_rises; f0 = fe_pulses; start = cyc;
        send_frame(8'h41, 1'b1, 1);
        wait_cycles(4);
        lat = rise_cyc - start;
        n_checks++; if (valid_rises !== r0 + 1) begin n_fail++; $display("FAIL basic_rises: got %0d expected %0d", valid_rises, r0 + 1); end
        n_checks++; if (lat < 154 || lat > 156) begin n_fail++; $display("FAIL basic_latency: got %0d expected 154..156", lat); end
        n_checks++; if (dataOut !== 8'h41) begin n_fail++; $display("FAIL basic_data: got %h expected 41", dataOut); end
        n_checks++; if (dataValid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", dataValid); end
        n_checks++; if (overrun !== 1'b0 || fe_pulses !== f0) begin n_fail++; $display("FAIL basic_errors: got overrun=%b fe=%0d expected 0 %0d", overrun, fe_pulses, f0); end
        pulse_ack();
        n_checks++; if (dataValid !== 1'b0) begin n_fail++; $display("FAIL basic_ack: got %b expected 0", dataValid); end
    endtask

    task automatic test_glitch();
        int r0, f0;
        r0 = valid_rises; f0 = fe_pulses;
        uart_rx = 1'b0;
        wait_cycles(4);
        uart_rx = 1'b1;
        n_checks++; if (rxBusy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi: got %b expected 1", rxBusy); end
        wait_cycles(20);
        n_checks++; if (rxBusy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_lo: got %b expected 0", rxBusy); end
        n_checks++; if (valid_rises !== r0 || fe_pulses !== f0) begin n_fail++; $display("FAIL glitch_report: got rises=%0d fe=%0d expected %0d %0d", valid_rises, fe_pulses, r0, f0); end
    endtask

    task automatic test_frame_error();
        int f0, h0;
        f0 = fe_pulses; h0 = fe_hi;
        send_frame(8'h55, 1'b0, 3);
        n_checks++; if (fe_pulses !== f0 + 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d expected %0d", fe_pulses, f0 + 1); end
        n_checks++; if (fe_hi - h0 !== 1) begin n_fail++; $display("FAIL ferr_width: got %0d expected 1", fe_hi - h0); end
        n_checks++; if (dataValid !== 1'b0) begin n_fail++; $display("FAIL ferr_valid: got %b expected 0", dataValid); end
        n_checks++; if (rxBusy !== 1'b1) begin n_fail++; $display("FAIL ferr_busy_held: got %b expected 1", rxBusy); end
        uart_rx = 1'b1;
        wait_cycles(6);
        n_checks++; if (rxBusy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy_release: got %b expected 0", rxBusy); end
        send_frame(8'hA3, 1'b1, 1);
        wait_cycles(4);
        n_checks++; if (dataOut !== 8'hA3 || dataValid !== 1'b1) begin n_fail++; $display("FAIL ferr_recover: got %h/%b expected a3/1", dataOut, dataValid); end
        pulse_ack();
    endtask

    task automatic test_back_to_back();
        send_frame(8'h12, 1'b1, 1);
        send_frame(8'h34, 1'b1, 1);
        wait_cycles(4);
        n_checks++; if (dataOut !== 8'h12) begin n_fail++; $display("FAIL b2b_data: got %h expected 12", dataOut); end
        n_checks++; if (overrun !== 1'b1 || dataValid !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got ovr=%b valid=%b expected 1 1", overrun, dataValid); end
        pulse_ack();
        n_checks++; if (overrun !== 1'b0 || dataValid !== 1'b0) begin n_fail++; $display("FAIL b2b_ack: got ovr=%b valid=%b expected 0 0", overrun, dataValid); end
        wait_cycles(20);
        n_checks++; if (dataValid !== 1'b0) begin n_fail++; $display("FAIL b2b_lost: got %b expected 0", dataValid); end
    endtask

    task automatic test_ack_on_delivery();
        send_frame(8'h12, 1'b1, 1);
        wait_cycles(4);
        n_checks++; if (dataOut !== 8'h12 || dataValid !== 1'b1) begin n_fail++; $display("FAIL ackdel_first: got %h/%b expected 12/1", dataOut, dataValid); end
        fork
            send_frame(8'h34, 1'b1, 1);
            begin
                repeat (155) @(posedge clock);
                #1 dataAck = 1'b1;
                @(posedge clock);
                #1 dataAck = 1'b0;
            end
        join
        wait_cycles(4);
        n_checks++; if (dataOut !== 8'h34) begin n_fail++; $display("FAIL ackdel_data: got %h expected 34", dataOut); end
        n_checks++; if (dataValid !== 1'b1 || overrun !== 1'b0) begin n_fail++; $display("FAIL ackdel_flags: got valid=%b ovr=%b expected 1 0", dataValid, overrun); end
    endtask

    task automatic test_reset_midframe();
        int r0;
        r0 = valid_rises;
        fork
            send_frame(8'hFF, 1'b1, 1);
            begin
                repeat (85) @(posedge clock);
                #1 reset = 1'b1;
                @(posedge clock);
                #1;
                n_checks++; if ({dataOut, dataValid, frameError, overrun, rxBusy} !== 12'h000) begin n_fail++; $display("FAIL midrst_outputs: got %h/%b%b%b%b expected 00/0000", dataOut, dataValid, frameError, overrun, rxBusy); end
                reset = 1'b0;
            end
        join
        wait_cycles(8);
        n_checks++; if (valid_rises !== r0 || rxBusy !== 1'b0) begin n_fail++; $display("FAIL midrst_nobyte: got rises=%0d busy=%b expected %0d 0", valid_rises, rxBusy, r0); end
        send_frame(8'h7E, 1'b1, 1);
        wait_cycles(4);
        n_checks++; if (dataOut !== 8'h7E || dataValid !== 1'b1) begin n_fail++; $display("FAIL midrst_next: got %h/%b expected 7e/1", dataOut, dataValid); end
        pulse_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_ack_on_delivery();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- 8N1 UART receiver, the companion to the existing UART transmitter. Same CLOCK_SPEED / BAUD_RATE parameterisation and the same bit-period arithmetic.
- Synchronises the asynchronous uart_rx pin, qualifies the start bit at mid-bit, and samples 8 data bits LSB-first plus the stop bit at bit centres.
- Presents each byte through a valid/ack holding register to the top-level logic, with frame-error and overrun reporting.

Parameters:
- CLOCK_SPEED, 27000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- Derived, not overridable: CLOCK_DELAY = CLOCK_SPEED / BAUD_RATE (integer division, clocks per bit) and HALF_DELAY = CLOCK_DELAY / 2.
- CLOCK_DELAY must be at least 4; elaboration error otherwise.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial line; idles high.
- dataOut  output  8  last accepted byte; stable while dataValid=1.
- dataValid  output  1  byte available; held until dataAck.
- dataAck  input  1  consumer takes the byte; only meaningful when dataValid=1.
- frameError  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky: a byte was lost because dataValid was still pending.
- rxBusy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: state=IDLE, dataOut=0, dataValid=0, frameError=0, overrun=0, rxBusy=0, both synchroniser flops=1, counters=0.
- Reset mid-frame aborts the frame; no byte and no error is reported.
- Synchroniser: two flops. rxS is the second flop, so each pin change reaches the FSM 2 cycles later. The FSM uses only rxS.
- Bit counter: 32-bit clkCnt. Bit index: 3-bit bitIdx.
- IDLE: when rxS=0, go to START with clkCnt=0.
- START: increment clkCnt. When clkCnt==HALF_DELAY-1, sample rxS:
  - rxS=0: go to DATA with clkCnt=0, bitIdx=0.
  - rxS=1: glitch; return to IDLE with no report.
- DATA: increment clkCnt. When clkCnt==CLOCK_DELAY-1, sample rxS into shift[bitIdx] (LSB first) and set clkCnt=0.
  - After bitIdx==7 is sampled, go to STOP; otherwise increment bitIdx.
- STOP: when clkCnt==CLOCK_DELAY-1, sample rxS:
  - rxS=1: deliver the byte (see delivery rules) and go to IDLE.
  - rxS=0: pulse frameError for exactly 1 cycle, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH (break/line-low recovery): stay until rxS=1, then go to IDLE. No new start is detected until then.
- Delivery, in the cycle after the stop sample:
  - dataValid=0: dataOut<=shift, dataValid<=1.
  - dataValid=1 and dataAck=1 in the same cycle: load the new byte; dataValid stays 1; no overrun.
  - dataValid=1 and dataAck=0: keep the old dataOut and discard the new byte; overrun<=1.
- dataAck with dataValid=1 and no delivery that cycle: dataValid<=0 and overrun<=0 on the next edge.
- dataAck with dataValid=0: ignored.
- Latency: dataValid rises 2 + HALF_DELAY + 9*CLOCK_DELAY + 1 cycles (±1) after the pin falling edge of the start bit.
- Back-to-back frames: a new start bit immediately following a good stop sample is accepted, because IDLE is re-entered at mid-stop-bit.
- Arithmetic: counters wrap-free by construction; clkCnt never exceeds CLOCK_DELAY-1.

Test Plan (CLOCK_SPEED=1600, BAUD_RATE=100, so CLOCK_DELAY=16 and HALF_DELAY=8, unless noted):
- Send 0x41 with a 16-cycle bit period and stop=1 -> dataValid rises about 155 cycles after the start edge, dataOut=0x41, frameError and overrun stay 0; pulse dataAck -> dataValid=0 next cycle.
- Drive a 4-cycle low glitch on idle uart_rx -> FSM returns to IDLE, rxBusy falls, no dataValid and no frameError.
- Send 0x55 with the stop bit held low for 3 bit times -> one 1-cycle frameError pulse, dataValid stays 0; rxBusy stays high until the line is high again; then 0xA3 is received correctly.
- Send 0x12 then 0x34 back-to-back without ack -> dataOut=0x12, overrun=1; dataAck -> dataValid=0, overrun=0; 0x34 is lost.
- Send 0x12, then assert dataAck exactly in the delivery cycle of 0x34 -> dataOut=0x34, dataValid=1, overrun=0.
- Assert reset during DATA bit 4 of 0xFF -> all outputs 0 next cycle, no byte delivered; the next frame 0x7E is received correctly.
